// File: rtl/mux_arb_nx1.sv
// NUM_IN:1 registered operand multiplexer with fixed-select or round-robin arbitration,
// valid/ready flow control on both sides and a source tag on the output word.
module mux_arb_nx1 #(
    parameter int DATA_WDTH = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_WDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IN*DATA_WDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]             in_valid,
    output logic [NUM_IN-1:0]             in_ready,
    input  logic                          mode,
    input  logic [SEL_WDTH-1:0]           sel,
    output logic [DATA_WDTH-1:0]          out_data,
    output logic [SEL_WDTH-1:0]           out_src,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic [DATA_WDTH-1:0] out_data_r;
    logic [SEL_WDTH-1:0]  out_src_r;
    logic                 out_valid_r;
    logic [SEL_WDTH-1:0]  rr_ptr_r;

    logic                 load_en_s;
    logic                 fix_vld_s;
    logic                 rr_vld_s;
    logic [SEL_WDTH-1:0]  rr_grant_s;
    logic [SEL_WDTH-1:0]  grant_s;
    logic                 grant_vld_s;
    logic [SEL_WDTH-1:0]  rr_next_s;
    logic [DATA_WDTH-1:0] sel_data_s;
    logic [NUM_IN-1:0]    in_ready_s;
    int                   rr_dist_s;
    int                   rr_best_s;

    // Output register can accept a word when empty or draining this cycle.
    assign load_en_s = !out_valid_r || out_ready;

    // Fixed-mode request check; an out-of-range sel matches no channel.
    always_comb begin
        fix_vld_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if ((SEL_WDTH'(i) == sel) && in_valid[i]) begin
                fix_vld_s = 1'b1;
            end else begin
                fix_vld_s = fix_vld_s;
            end
        end
    end

    // Round-robin pick: the valid channel closest to rr_ptr going upward with wrap.
    always_comb begin
        rr_vld_s   = 1'b0;
        rr_grant_s = '0;
        rr_best_s  = NUM_IN;
        rr_dist_s  = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            rr_dist_s = (i + NUM_IN - int'(rr_ptr_r)) % NUM_IN;
            if (in_valid[i] && (rr_dist_s < rr_best_s)) begin
                rr_best_s  = rr_dist_s;
                rr_grant_s = SEL_WDTH'(i);
                rr_vld_s   = 1'b1;
            end else begin
                rr_best_s  = rr_best_s;
            end
        end
    end

    // Mode select between the two grant sources.
    always_comb begin
        grant_s     = sel;
        grant_vld_s = fix_vld_s;
        if (mode) begin
            grant_s     = rr_grant_s;
            grant_vld_s = rr_vld_s;
        end else begin
            grant_s     = sel;
            grant_vld_s = fix_vld_s;
        end
    end

    // Data steering and one-hot ready generation for the granted channel.
    always_comb begin
        sel_data_s = '0;
        in_ready_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_s == SEL_WDTH'(i)) begin
                sel_data_s    = in_data[i*DATA_WDTH +: DATA_WDTH];
                in_ready_s[i] = rst_n && load_en_s && grant_vld_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Pointer moves one past the granted channel, wrapping at NUM_IN.
    always_comb begin
        rr_next_s = '0;
        if (int'(grant_s) >= NUM_IN - 1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_s + SEL_WDTH'(1);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_src_r   <= '0;
            out_valid_r <= 1'b0;
            rr_ptr_r    <= '0;
        end else if (load_en_s) begin
            if (grant_vld_s) begin
                out_data_r  <= sel_data_s;
                out_src_r   <= grant_s;
                out_valid_r <= 1'b1;
                if (mode) begin
                    rr_ptr_r <= rr_next_s;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign out_valid = out_valid_r;

endmodule
